// File: rtl/cpu_mem.sv
// cpu_mem: byte-serial program loader into instruction memory, then CPU-facing
// instruction/data memories with the CPU held in reset until loading completes.
module cpu_mem #(
  parameter int IWORDS = 128,
  parameter int DBYTES = 256
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  PC,
  output logic [15:0] Iout,
  input  logic [7:0]  ADDR,
  input  logic [7:0]  WDATA,
  input  logic        MW,
  output logic [7:0]  Dout,
  input  logic        LD_VALID,
  input  logic [7:0]  LD_DATA,
  input  logic        LD_DONE,
  output logic        LD_READY,
  output logic        CPU_RST,
  output logic [7:0]  WORDS
);
  typedef enum logic [1:0] {LOAD_LO, LOAD_HI, RUN} state_t;
  state_t      state_q, state_d;
  logic [6:0]  ptr_q, ptr_d;
  logic [7:0]  lo_q, lo_d, words_q, words_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        iwe;
  logic [15:0] iwdata;
  logic [15:0] imem [IWORDS];
  logic [7:0]  dmem [DBYTES];
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    iwe     = 1'b0;
    iwdata  = {8'h00, lo_q};
    if (state_q == LOAD_LO) begin
      if (LD_VALID) begin
        lo_d    = LD_DATA;
        state_d = LOAD_HI;
      end
      // A byte arriving together with end-of-program becomes a padded word.
      if (LD_DONE) begin
        iwe     = LD_VALID;
        iwdata  = {8'h00, LD_DATA};
        state_d = RUN;
      end
    end else if (state_q == LOAD_HI && (LD_VALID || LD_DONE)) begin
      iwe     = 1'b1;
      iwdata  = LD_VALID ? {LD_DATA, lo_q} : {8'h00, lo_q};
      state_d = LD_DONE ? RUN : LOAD_LO;
    end
    ptr_d     = iwe ? ptr_q + 7'd1 : ptr_q;
    words_d   = (iwe && words_q != 8'(IWORDS)) ? words_q + 8'd1 : words_q;
    cpu_rst_d = state_d != RUN;
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= LOAD_LO;
      ptr_q     <= '0;
      lo_q      <= '0;
      words_q   <= '0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lo_q      <= lo_d;
      words_q   <= words_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end
  // Memories are never cleared; reset only suppresses writes in its cycle.
  always_ff @(posedge CLK) begin
    if (RESET && iwe) imem[ptr_q] <= iwdata;
    if (RESET && MW && state_q == RUN) dmem[ADDR] <= WDATA;
  end
  assign Iout     = imem[PC[7:1]];
  assign Dout     = dmem[ADDR];
  assign LD_READY = state_q != RUN;
  assign CPU_RST  = cpu_rst_q;
  assign WORDS    = words_q;
endmodule

// File: tb/tb_cpu_mem.sv
// tb_cpu_mem: directed checks of loading, wrap/saturation, data memory and reset.
module tb_cpu_mem;
  logic        CLK, RESET, MW, LD_VALID, LD_DONE, LD_READY, CPU_RST;
  logic [7:0]  PC, ADDR, WDATA, Dout, LD_DATA, WORDS;
  logic [15:0] Iout;
  int tests = 0, fails = 0;

  cpu_mem dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .Iout(Iout), .ADDR(ADDR), .WDATA(WDATA),
    .MW(MW), .Dout(Dout), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .LD_DONE(LD_DONE),
    .LD_READY(LD_READY), .CPU_RST(CPU_RST), .WORDS(WORDS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    LD_VALID = 1'b1;
    LD_DATA  = b;
    tick();
    LD_VALID = 1'b0;
  endtask

  task automatic done();
    LD_DONE = 1'b1;
    tick();
    LD_DONE = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
  endtask

  task automatic iat(input string tag, input logic [7:0] pc, input logic [15:0] exp);
    PC = pc;
    #1;
    chk(tag, Iout, exp);
  endtask

  initial begin
    RESET = 1'b1; PC = '0; ADDR = '0; WDATA = '0; MW = 1'b0;
    LD_VALID = 1'b0; LD_DATA = '0; LD_DONE = 1'b0;
    #2;
    do_reset();
    chk("rst_cpu_rst", 16'(CPU_RST), 16'h1);
    chk("rst_ld_ready", 16'(LD_READY), 16'h1);
    chk("rst_words", 16'(WORDS), 16'h0);

    // Two words then end-of-program in LOAD_LO
    send(8'h34); send(8'h12); send(8'h78); send(8'h56);
    chk("s1_words_pre", 16'(WORDS), 16'h2);
    chk("s1_cpu_rst_pre", 16'(CPU_RST), 16'h1);
    done();
    chk("s1_cpu_rst_fell", 16'(CPU_RST), 16'h0);
    chk("s1_ld_ready_run", 16'(LD_READY), 16'h0);
    chk("s1_words", 16'(WORDS), 16'h2);
    iat("s1_i0", 8'h00, 16'h1234);
    iat("s1_i1", 8'h02, 16'h5678);
    iat("s1_pc0_ignored", 8'h03, 16'h5678);

    // Data memory in RUN: pre-write value visible during the write cycle
    ADDR = 8'h10; WDATA = 8'h11; MW = 1'b1;
    tick();
    WDATA = 8'h5A;
    #1;
    chk("s4_dout_old", 16'(Dout), 16'h0011);
    tick();
    MW = 1'b0;
    chk("s4_dout_new", 16'(Dout), 16'h005A);

    // Loader ignored in RUN
    send(8'hEE); send(8'hFF); done();
    chk("run_words_hold", 16'(WORDS), 16'h2);
    iat("run_imem_hold", 8'h00, 16'h1234);
    chk("run_cpu_rst_hold", 16'(CPU_RST), 16'h0);

    // Single byte, LD_DONE in LOAD_HI; MW during load ignored
    do_reset();
    ADDR = 8'h10; WDATA = 8'hFF; MW = 1'b1;
    tick();
    MW = 1'b0;
    send(8'hAB);
    chk("s2_ld_ready_hi", 16'(LD_READY), 16'h1);
    done();
    chk("s2_words", 16'(WORDS), 16'h1);
    chk("s2_cpu_rst", 16'(CPU_RST), 16'h0);
    chk("s2_ld_ready", 16'(LD_READY), 16'h0);
    iat("s2_i0", 8'h00, 16'h00AB);
    iat("s2_i1_kept", 8'h02, 16'h5678);
    #1;
    chk("s4_mw_in_load", 16'(Dout), 16'h005A);

    // Valid and done together in LOAD_LO
    do_reset();
    LD_VALID = 1'b1; LD_DATA = 8'h12; LD_DONE = 1'b1;
    tick();
    LD_VALID = 1'b0; LD_DONE = 1'b0;
    chk("s5_words", 16'(WORDS), 16'h1);
    chk("s5_cpu_rst", 16'(CPU_RST), 16'h0);
    iat("s5_i0", 8'h00, 16'h0012);

    // Reset in RUN beats a pending data write
    ADDR = 8'h10; WDATA = 8'h77; MW = 1'b1; RESET = 1'b0;
    tick();
    MW = 1'b0; RESET = 1'b1;
    chk("s6_write_dropped", 16'(Dout), 16'h005A);

    // Reset mid-load restarts at word 0
    send(8'h01); send(8'h02); send(8'h03);
    chk("s6_words_pre", 16'(WORDS), 16'h1);
    do_reset();
    chk("s6_words", 16'(WORDS), 16'h0);
    chk("s6_cpu_rst", 16'(CPU_RST), 16'h1);
    chk("s6_ld_ready", 16'(LD_READY), 16'h1);
    send(8'hCD); send(8'hAB); done();
    chk("s6_words_after", 16'(WORDS), 16'h1);
    iat("s6_i0", 8'h00, 16'hABCD);

    // 130 words: pointer wraps, WORDS saturates
    do_reset();
    for (int k = 0; k < 130; k++) begin
      send(8'(k));
      send(8'(k) ^ 8'hA5);
    end
    chk("s3_words_sat", 16'(WORDS), 16'd128);
    chk("s3_still_loading", 16'(CPU_RST), 16'h1);
    done();
    chk("s3_run", 16'(CPU_RST), 16'h0);
    iat("s3_i0_word128", 8'h00, 16'h2580);
    iat("s3_i1_word129", 8'h02, 16'h2481);
    iat("s3_i2_word2", 8'h04, 16'hA702);
    iat("s3_i127", 8'hFE, 16'hDA7F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
